// File: rtl/dig_clock_gen2_if.sv
// Button inputs and display outputs of the time-of-day clock.
//   adv_hr, adv_min : raw button levels (asynchronous to clk)
//   segs_n          : segments {g,f,e,d,c,b,a}, active low
//   dp_n            : decimal point, active low
//   an_n            : digit anodes, active low, bit 0 = rightmost digit
interface dig_clock_gen2_if;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 8;

    logic             adv_hr;
    logic             adv_min;
    logic [SEG_W-1:0] segs_n;
    logic             dp_n;
    logic [AN_W-1:0]  an_n;

    modport master (output adv_hr, output adv_min,
                    input  segs_n, input dp_n, input an_n);
    modport slave  (input  adv_hr, input adv_min,
                    output segs_n, output dp_n, output an_n);
endinterface

// File: rtl/dig_clock_gen2.sv
// Six-digit time-of-day clock (24h or 12h display) driving a scanned,
// active-low seven-segment display, with auto-repeating advance buttons.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : slave side of dig_clock_gen2_if (buttons in, display out)
module dig_clock_gen2 #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter int unsigned REPEAT_DIV = 50_000_000,
    parameter int unsigned MODE_12H   = 0
) (
    input  logic             clk,
    input  logic             rst,
    dig_clock_gen2_if.slave  bus
);
    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned RPT_W  = $clog2(REPEAT_DIV);
    localparam int unsigned NBTN   = 2;   // bit 0 = minutes, bit 1 = hours

    logic [TICK_W-1:0]           tick_cnt;
    logic [SCAN_W-1:0]           scan_cnt;
    logic [2:0]                  scan_idx;
    logic [5:0]                  sec, min;
    logic [4:0]                  hr;
    logic [NBTN-1:0]             sync1, sync2, prev;
    logic [NBTN-1:0][RPT_W-1:0]  rpt_cnt;

    logic                        tick, scan_step;
    logic [NBTN-1:0]             btn_raw, rise, rpt_hit, adv;
    logic                        sec_wrap, min_wrap;
    logic [5:0]                  sec_nxt, min_nxt;
    logic [4:0]                  hr_nxt, hr_disp;
    logic [3:0]                  digit;
    logic                        blank, pm;
    logic [6:0]                  segs_d;
    logic                        dp_d;
    logic [7:0]                  an_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign btn_raw   = {bus.adv_hr, bus.adv_min};
    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign scan_step = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    // Advance on a fresh press, then again every REPEAT_DIV cycles while held.
    always_comb begin
        rise    = '0;
        rpt_hit = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            rise[i]    = sync2[i] & ~prev[i];
            rpt_hit[i] = sync2[i] & prev[i] & (rpt_cnt[i] == RPT_W'(REPEAT_DIV - 1));
        end
        adv = rise | rpt_hit;
    end

    // Next time value; a button advance absorbs a same-cycle carry into its field.
    always_comb begin
        sec_wrap = tick && (sec == 6'd59);
        min_wrap = sec_wrap && (min == 6'd59) && !adv[0];
        sec_nxt  = sec;
        min_nxt  = min;
        hr_nxt   = hr;
        if (tick)
            sec_nxt = sec_wrap ? 6'd0 : sec + 6'd1;
        if (adv[0] || sec_wrap)
            min_nxt = (min == 6'd59) ? 6'd0 : min + 6'd1;
        if (adv[1] || min_wrap)
            hr_nxt = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
    end

    // Digit selection and segment/decimal-point encoding for the scanned digit.
    always_comb begin
        pm      = (hr >= 5'd12);
        hr_disp = hr;
        if (MODE_12H != 0) begin
            hr_disp = pm ? hr - 5'd12 : hr;
            if (hr_disp == 5'd0)
                hr_disp = 5'd12;
        end
        blank = 1'b0;
        dp_d  = 1'b1;
        case (scan_idx)
            3'd0: begin
                digit = 4'(sec % 6'd10);
                dp_d  = ~((MODE_12H != 0) && pm);
            end
            3'd1: digit = 4'(sec / 6'd10);
            3'd2: begin
                digit = 4'(min % 6'd10);
                dp_d  = sec[0];
            end
            3'd3: digit = 4'(min / 6'd10);
            3'd4: begin
                digit = 4'(hr_disp % 5'd10);
                dp_d  = sec[0];
            end
            default: begin
                digit = 4'(hr_disp / 5'd10);
                blank = (MODE_12H != 0) && (hr_disp < 5'd10);
            end
        endcase
        segs_d = blank ? 7'h7F : seg7(digit);
        an_d   = ~(8'b0000_0001 << scan_idx);
    end

    // Dividers, button path, time state and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            scan_cnt   <= '0;
            scan_idx   <= '0;
            sec        <= '0;
            min        <= '0;
            hr         <= '0;
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            rpt_cnt    <= '0;
            bus.segs_n <= 7'h40;
            bus.dp_n   <= 1'b1;
            bus.an_n   <= 8'hFE;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            scan_cnt <= scan_step ? '0 : scan_cnt + SCAN_W'(1);
            if (scan_step)
                scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
            sync1 <= btn_raw;
            sync2 <= sync1;
            prev  <= sync2;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (!sync2[i] || adv[i])
                    rpt_cnt[i] <= '0;
                else
                    rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
            end
            sec        <= sec_nxt;
            min        <= min_nxt;
            hr         <= hr_nxt;
            bus.segs_n <= segs_d;
            bus.dp_n   <= dp_d;
            bus.an_n   <= an_d;
        end
    end
endmodule

// File: tb/tb_dig_clock_gen2.sv
// Scoreboard bench: two clocks (24h and 12h) share buttons and reset; expected
// display frames are queued by the stimulus and checked digit by digit as the
// scan presents each digit.
module tb_dig_clock_gen2;
    localparam int unsigned TICK_DIV   = 100;
    localparam int unsigned SCAN_DIV   = 2;
    localparam int unsigned REPEAT_DIV = 20;

    typedef struct packed {
        logic [5:0][6:0] segs24;
        logic [5:0]      dp24;
        logic [5:0][6:0] segs12;
        logic [5:0]      dp12;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adv_hr, adv_min;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    frame_t      exp_q[$];
    string       name_q[$];
    logic [5:0]  seen = '0;

    dig_clock_gen2_if if24();
    dig_clock_gen2_if if12();

    assign if24.adv_hr  = adv_hr;
    assign if24.adv_min = adv_min;
    assign if12.adv_hr  = adv_hr;
    assign if12.adv_min = adv_min;

    dig_clock_gen2 #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                     .REPEAT_DIV(REPEAT_DIV), .MODE_12H(0))
        dut24 (.clk(clk), .rst(rst), .bus(if24));
    dig_clock_gen2 #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                     .REPEAT_DIV(REPEAT_DIV), .MODE_12H(1))
        dut12 (.clk(clk), .rst(rst), .bus(if12));

    always #5 clk = ~clk;

    // Edges since reset release.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic frame_t mk(input int h, input int m, input int s);
        frame_t f;
        int     h12;
        f.segs24[0] = seg(s % 10);  f.segs24[1] = seg(s / 10);
        f.segs24[2] = seg(m % 10);  f.segs24[3] = seg(m / 10);
        f.segs24[4] = seg(h % 10);  f.segs24[5] = seg(h / 10);
        h12 = h % 12;
        if (h12 == 0) h12 = 12;
        f.segs12[3:0] = f.segs24[3:0];
        f.segs12[4]   = seg(h12 % 10);
        f.segs12[5]   = (h12 < 10) ? 7'h7F : seg(h12 / 10);
        f.dp24 = 6'h3F;
        if (s % 2 == 0) begin
            f.dp24[2] = 1'b0;
            f.dp24[4] = 1'b0;
        end
        f.dp12 = f.dp24;
        if (h >= 12) f.dp12[0] = 1'b0;
        return f;
    endfunction

    function automatic int an_index(input logic [7:0] an);
        logic [7:0] m;
        for (int i = 0; i < 6; i++) begin
            m = 8'b0000_0001 << i;
            if (an == ~m) return i;
        end
        return -1;
    endfunction

    function automatic void cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compare each presented digit against the head frame.
    initial begin
        int     i24, i12;
        frame_t cur;
        string  nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                cur = exp_q[0];
                nm  = name_q[0];
                i24 = an_index(if24.an_n);
                i12 = an_index(if12.an_n);
                n_checks++;
                if (i24 < 0 || i24 != i12) begin
                    n_fail++;
                    $display("FAIL %s an_n: got %h/%h, required one matching digit 0..5 active",
                             nm, if24.an_n, if12.an_n);
                end else begin
                    cmp($sformatf("%s segs24 d%0d", nm, i24), {1'b0, if24.segs_n}, {1'b0, cur.segs24[i24]});
                    cmp($sformatf("%s dp24 d%0d",   nm, i24), {7'b0, if24.dp_n},   {7'b0, cur.dp24[i24]});
                    cmp($sformatf("%s segs12 d%0d", nm, i24), {1'b0, if12.segs_n}, {1'b0, cur.segs12[i24]});
                    cmp($sformatf("%s dp12 d%0d",   nm, i24), {7'b0, if12.dp_n},   {7'b0, cur.dp12[i24]});
                    seen[i24] = 1'b1;
                    if (&seen) begin
                        void'(exp_q.pop_front());
                        void'(name_q.pop_front());
                        seen = '0;
                    end
                end
            end
        end
    end

    task automatic wait_edge(input int unsigned e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic check(input frame_t f, input string nm);
        exp_q.push_back(f);
        name_q.push_back(nm);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: digits seen %b, required 111111", nm, seen);
            exp_q.delete();
            name_q.delete();
            seen = '0;
        end
    endtask

    // Hold both buttons from this negedge; each released after its own count.
    task automatic hold_both(input int n_hr, input int n_min);
        int n;
        n = (n_hr > n_min) ? n_hr : n_min;
        adv_hr  = (n_hr  > 0);
        adv_min = (n_min > 0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == n_hr)  adv_hr  = 1'b0;
            if (i == n_min) adv_min = 1'b0;
        end
    endtask

    initial begin
        frame_t f;
        adv_hr  = 1'b0;
        adv_min = 1'b0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst an24",   if24.an_n,          8'hFE);
        cmp("rst segs24", {1'b0, if24.segs_n}, 8'h40);
        cmp("rst dp24",   {7'b0, if24.dp_n},   8'h01);
        cmp("rst an12",   if12.an_n,          8'hFE);
        cmp("rst segs12", {1'b0, if12.segs_n}, 8'h40);
        cmp("rst dp12",   {7'b0, if12.dp_n},   8'h01);
        rst = 1'b0;

        wait_edge(2);     check(mk(0, 0, 0), "midnight");
        wait_edge(105);   check(mk(0, 0, 1), "first_tick");

        wait_edge(200);   hold_both(0, 1170);            // 59 minute advances
        wait_edge(1405);  check(mk(0, 59, 14), "min59");
        wait_edge(1410);  hold_both(0, 1);               // single press wraps min
        wait_edge(1420);  check(mk(0, 0, 14), "min_wrap_no_carry");

        wait_edge(1500);  hold_both(0, 190);             // 10 minute advances
        wait_edge(1705);  check(mk(0, 10, 17), "min10");
        wait_edge(5905);  check(mk(0, 10, 59), "sec59");
        wait_edge(5997);  hold_both(0, 1);               // advance lands on the tick edge
        wait_edge(6005);  check(mk(0, 11, 0), "collision");

        wait_edge(6010);  hold_both(45, 0);              // initial + 2 repeats
        wait_edge(6105);  check(mk(3, 11, 1), "hold45");

        wait_edge(6110);  hold_both(190, 1050);          // hr +10, min +53
        wait_edge(7205);  check(mk(13, 4, 12), "both_buttons");
        wait_edge(12005); check(mk(13, 5, 0), "sec_carry_min");

        wait_edge(12805);
        f.segs24 = {7'h79, 7'h30, 7'h40, 7'h12, 7'h40, 7'h00};
        f.dp24   = 6'b101011;
        f.segs12 = {7'h7F, 7'h79, 7'h40, 7'h12, 7'h40, 7'h00};
        f.dp12   = 6'b101010;
        check(f, "pm_13_05_08");

        wait_edge(12810); hold_both(190, 1070);          // hr +10, min +54
        wait_edge(13905); check(mk(23, 59, 19), "preload");
        wait_edge(17905); check(mk(23, 59, 59), "pre_rollover");
        wait_edge(18005); check(mk(0, 0, 0), "rollover");

        wait_edge(18010); adv_hr = 1'b1;
        wait_edge(18020); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_edge(10);    adv_hr = 1'b0;
        wait_edge(15);    check(mk(1, 0, 0), "rst_mid_press");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
